// File: rtl/adder_share_arb_pkg.sv
// adder_share_arb_pkg: shared types and constants for the adder-sharing arbiter.
//   arb_state_t  - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   DEF_*        - default parameter values
//   PTR_W/CNT_W  - width of requester indices (up to 8 requesters) and latency counter
//   rr_next()    - round-robin successor of a requester index
package adder_share_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 2;
  localparam int unsigned DEF_ADD_LAT = 1;
  localparam int unsigned DEF_TIMEOUT = 16;

  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input int unsigned        n);
    return PTR_W'((32'(ptr) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: bundle of requester-side and adder-side signals.
//   req_valid/req_ready/req_a/req_b - request handshake and flat operands
//   rsp_valid/rsp_ready/rsp_c       - response handshake and shared result bus
//   add_a/add_b/add_valid/add_c     - shared adder pins
//   err_timeout                     - dropped-response pulse
// modport master: the arbiter; modport slave: requesters plus adder.
interface adder_share_arb_if
  import adder_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W:0]           rsp_c;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic                      add_valid;
  logic [DATA_W:0]           add_c;
  logic                      err_timeout;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, add_c,
    output req_ready, rsp_valid, rsp_c, add_a, add_b, add_valid, err_timeout
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, add_c,
    input  req_ready, rsp_valid, rsp_c, add_a, add_b, add_valid, err_timeout
  );

endinterface

// File: rtl/adder_share_arb_rr_pick.sv
// adder_share_arb_rr_pick: combinational round-robin winner search.
//   req_valid - per-requester request
//   ptr       - index searched first; search goes upward with wrap
//   gnt_oh    - one-hot winner (all zero if nothing pending)
//   gnt_idx   - encoded winner index
//   gnt_any   - a winner exists
module adder_share_arb_rr_pick
  import adder_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  int unsigned idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter/sequencer sharing one registered adder
// among NUM_REQ requesters, one transaction in flight at a time.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - adder_share_arb_if.master (request/response handshakes, adder pins,
//           err_timeout)
// Optional feature macro ADDER_SHARE_ARB_TIMEOUT_EN: drop a response that is not
// accepted within TIMEOUT RESP cycles and pulse err_timeout.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  adder_share_arb_if.master bus
);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  logic                add_valid_q, add_valid_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]     rsp_c_q, rsp_c_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                rsp_hit;
  logic                rsp_drop;

  adder_share_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .gnt_oh    (pick_oh),
    .gnt_idx   (pick_idx),
    .gnt_any   (pick_any)
  );

  // rsp_valid_q is one-hot on gnt in RESP, so it doubles as the rsp_ready select.
  assign rsp_hit = |(bus.rsp_ready & rsp_valid_q);

`ifdef ADDER_SHARE_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic        err_q;

  assign rsp_drop = (state_q == RESP) && !rsp_hit && (tcnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    tcnt_d = '0;
    if (state_q == RESP) tcnt_d = tcnt_q + 16'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= rsp_drop;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign rsp_drop        = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    unique case (state_q)
      IDLE: begin
        // The adder operand registers double as the latched request operands.
        if (pick_any) begin
          gnt_d       = pick_idx;
          add_a_d     = bus.req_a[32'(pick_idx)*DATA_W +: DATA_W];
          add_b_d     = bus.req_b[32'(pick_idx)*DATA_W +: DATA_W];
          add_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ADD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_c_d     = bus.add_c;
          rsp_valid_d = NUM_REQ'(1) << gnt_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_hit || rsp_drop) begin
          rsp_valid_d = '0;
          ptr_d       = rr_next(gnt_q, NUM_REQ);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_valid_q <= add_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  // Gated by reset so no accept strobe is visible while reset is held.
  assign bus.req_ready = (reset && state_q == IDLE) ? pick_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_valid = add_valid_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed plus randomized bench for adder_share_arb with a
// behavioural adder and a transaction-level model of grant order and sums.
module tb_adder_share_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 2;
  localparam int unsigned AL = 1;
  localparam int unsigned TO = 16;

  logic clk;
  logic reset;
  int   cyc_cnt;
  int   n_checks;
  int   n_errors;

  adder_share_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  adder_share_arb #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ADD_LAT (AL),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural adder, AL cycles from add_valid to add_c; outside the valid
  // window it presents a deliberately wrong value.
  logic [DW:0] pipe_s [AL];
  logic        pipe_v [AL];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(AL); k++) pipe_v[k] <= 1'b0;
    end else begin
      pipe_s[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
      pipe_v[0] <= bus.add_valid;
      for (int k = 1; k < int'(AL); k++) begin
        pipe_s[k] <= pipe_s[k-1];
        pipe_v[k] <= pipe_v[k-1];
      end
    end
  end

  assign bus.add_c = pipe_v[AL-1] ? pipe_s[AL-1] : ~pipe_s[AL-1];

  // Reference model state: pending requests and round-robin pointer.
  logic              pend_v [NR];
  logic [DW-1:0]     pend_a [NR];
  logic [DW-1:0]     pend_b [NR];
  int unsigned       mptr;

  function automatic logic [NR-1:0] onehot(input int unsigned i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int unsigned model_pick(input int unsigned p);
    for (int unsigned d = 0; d < NR; d++)
      if (pend_v[(p + d) % NR]) return (p + d) % NR;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_c"},     64'(bus.rsp_c),     64'(0));
    check({tag, "_add_a"},     64'(bus.add_a),     64'(0));
    check({tag, "_add_b"},     64'(bus.add_b),     64'(0));
    check({tag, "_add_valid"}, 64'(bus.add_valid), 64'(0));
    check({tag, "_err"},       64'(bus.err_timeout), 64'(0));
  endtask

  // One transaction from the IDLE negedge with requests already driven.
  // hold = number of RESP cycles during which rsp_ready[idx] is low.
  task automatic run_one(input int unsigned idx, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int unsigned hold,
                         output int hs_cyc);
    int unsigned sum;
    sum = int'(a) + int'(b);
    #1;
    check("req_ready_win", 64'(bus.req_ready), 64'(onehot(idx)));
    check("idle_add_valid", 64'(bus.add_valid), 64'(0));
    hs_cyc = cyc_cnt;
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    if (hold > 0) bus.rsp_ready[idx] = 1'b0;
    #1;
    check("issue_add_valid", 64'(bus.add_valid), 64'(1));
    check("issue_add_a", 64'(bus.add_a), 64'(a));
    check("issue_add_b", 64'(bus.add_b), 64'(b));
    check("issue_req_ready", 64'(bus.req_ready), 64'(0));
    check("issue_err", 64'(bus.err_timeout), 64'(0));
    repeat (AL) begin
      @(negedge clk); #1;
      check("wait_add_valid", 64'(bus.add_valid), 64'(0));
      check("wait_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    end
    @(negedge clk); #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(idx)));
    check("rsp_c", 64'(bus.rsp_c), 64'(sum));
    check("rsp_add_a_hold", 64'(bus.add_a), 64'(a));
    if (hold > 0) begin
      for (int unsigned h = 1; h < hold; h++) begin
        @(negedge clk); #1;
        check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(idx)));
        check("bp_rsp_c", 64'(bus.rsp_c), 64'(sum));
        check("bp_req_ready", 64'(bus.req_ready), 64'(0));
      end
      @(negedge clk);
      bus.rsp_ready[idx] = 1'b1;
      #1;
      check("bp_last_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(idx)));
    end
    @(negedge clk); #1;
    check("done_rsp_valid", 64'(bus.rsp_valid), 64'(0));
  endtask

  int          hs, prev_hs;
  int unsigned order [5];
  logic [DW-1:0] fa [NR];
  logic [DW-1:0] fb [NR];
  int unsigned w;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '1;
    bus.req_b     = '1;
    bus.rsp_ready = '1;
    for (int i = 0; i < int'(NR); i++) pend_v[i] = 1'b0;

    // Reset state, even with every request raised.
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("post_reset");

    // Fairness: all requesters valid, rsp_ready high -> 0,1,2,3,0 at AL+3 spacing.
    for (int unsigned i = 0; i < NR; i++) begin
      fa[i] = DW'($urandom);
      fb[i] = DW'($urandom);
      set_req(i, fa[i], fb[i]);
    end
    order = '{0, 1, 2, 3, 0};
    prev_hs = 0;
    for (int s = 0; s < 5; s++) begin
      run_one(order[s], fa[order[s]], fb[order[s]], 0, hs);
      if (s > 0) check("fair_spacing", 64'(hs - prev_hs), 64'(AL + 3));
      prev_hs = hs;
      if (s == 0) set_req(0, fa[0], fb[0]);
    end

    // Backpressure on requester 1 while requester 3 waits; then 3 is served.
    set_req(1, 2'd2, 2'd1);
    set_req(3, 2'd3, 2'd3);
    run_one(1, 2'd2, 2'd1, 10, hs);
    run_one(3, 2'd3, 2'd3, 0, hs);

    // Single request from 2 with 3+3 = 6.
    set_req(2, 2'd3, 2'd3);
    run_one(2, 2'd3, 2'd3, 0, hs);

    // Pointer now 3: requesters 0 and 3 valid -> 3 then 0.
    set_req(0, 2'd1, 2'd1);
    set_req(3, 2'd2, 2'd1);
    run_one(3, 2'd2, 2'd1, 0, hs);
    run_one(0, 2'd1, 2'd1, 0, hs);

    // Reset asserted in WAIT aborts the transaction.
    set_req(1, 2'd2, 2'd3);
    #1;
    check("rw_req_ready", 64'(bus.req_ready), 64'(onehot(1)));
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("reset_in_wait");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_release_req_ready", 64'(bus.req_ready), 64'(0));
    repeat (AL + 3) begin
      @(negedge clk); #1;
      check("rw_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    set_req(0, 2'd1, 2'd2);
    run_one(0, 2'd1, 2'd2, 0, hs);

    // Randomized traffic against the model.
    mptr = 1;
    for (int r = 0; r < 24; r++) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend_v[i] = 1'b1;
          pend_a[i] = DW'($urandom);
          pend_b[i] = DW'($urandom);
          set_req(i, pend_a[i], pend_b[i]);
        end
      end
      if (!(pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3])) begin
        w = $urandom_range(0, NR - 1);
        pend_v[w] = 1'b1;
        pend_a[w] = DW'($urandom);
        pend_b[w] = DW'($urandom);
        set_req(w, pend_a[w], pend_b[w]);
      end
      w = model_pick(mptr);
      run_one(w, pend_a[w], pend_b[w], $urandom_range(0, 3), hs);
      pend_v[w] = 1'b0;
      mptr = (w + 1) % NR;
    end

`ifdef ADDER_SHARE_ARB_TIMEOUT_EN
    // Unanswered response is dropped after TO RESP cycles; next requester follows.
    for (int unsigned i = 0; i < NR; i++) begin
      if (!pend_v[i]) begin
        pend_v[i] = 1'b1;
        pend_a[i] = DW'($urandom);
        pend_b[i] = DW'($urandom);
        set_req(i, pend_a[i], pend_b[i]);
      end
    end
    w = model_pick(mptr);
    #1;
    check("to_req_ready", 64'(bus.req_ready), 64'(onehot(w)));
    @(negedge clk);
    bus.req_valid[w] = 1'b0;
    bus.rsp_ready[w] = 1'b0;
    pend_v[w] = 1'b0;
    repeat (AL) @(negedge clk);
    for (int unsigned t = 0; t < TO; t++) begin
      @(negedge clk); #1;
      check("to_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(w)));
      check("to_err_low", 64'(bus.err_timeout), 64'(0));
    end
    @(negedge clk);
    bus.rsp_ready[w] = 1'b1;
    #1;
    check("to_err_pulse", 64'(bus.err_timeout), 64'(1));
    check("to_rsp_dropped", 64'(bus.rsp_valid), 64'(0));
    mptr = (w + 1) % NR;
    w = model_pick(mptr);
    run_one(w, pend_a[w], pend_b[w], 0, hs);
    pend_v[w] = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
